image_frame_ctrl: RTL and testbench

//   Parametrised frame timing/sequencing engine for the pixel-stream pipeline (image_read -> filter -> image_write).

---
 rtl/image_frame_ctrl.sv | 175 +++++++++++++++++
 tb/tb_image_frame_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/image_frame_ctrl.sv
// image_frame_ctrl: frame timing and sequencing engine for the pixel-stream pipeline.
// It issues one pixel strobe per ACTIVE cycle and tracks x/y coordinates.
// It inserts horizontal and vertical blanking, and runs NUM_FRAMES frames per start.
// Every output is registered. An output describes the action taken at the most recent clock edge.
//
// Ports:
//   HCLK, HRESETn  clock, synchronous active-low reset
//   start          run request (honoured only in IDLE)
//   mode_in        processing mode, latched into 'mode' on an accepted start
//   stall          backpressure, freezes the pixel stream while ACTIVE
//   abort          (FRAME_ABORT_EN only) returns a busy engine to IDLE
//   HSYNC          pixel (pix_x, pix_y) issued at the last edge
//   line_start     first pixel of a line
//   frame_start    first pixel of a frame
//   pix_x, pix_y   coordinates of the last issued pixel
//   frame_cnt      frames completed in this run
//   mode           mode latched at start
//   busy           run in progress (includes the DONE cycle)
//   done           one-cycle completion pulse
//
// Optional feature: define FRAME_ABORT_EN to add the 'abort' input.
module image_frame_ctrl #(
    parameter int unsigned IMG_W      = 768,
    parameter int unsigned IMG_H      = 512,
    parameter int unsigned H_BLANK    = 160,
    parameter int unsigned V_BLANK    = 2,
    parameter int unsigned NUM_FRAMES = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             start,
    input  logic [1:0]       mode_in,
    input  logic             stall,
`ifdef FRAME_ABORT_EN
    input  logic             abort,
`endif
    output logic             HSYNC,
    output logic             line_start,
    output logic             frame_start,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [1:0]       mode,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int unsigned BW        = (BLANK_MAX > 0) ? $clog2(BLANK_MAX + 1) : 1;
    localparam int unsigned HB_LAST   = (H_BLANK > 0) ? H_BLANK - 1 : 0;
    localparam int unsigned VB_LAST   = (V_BLANK > 0) ? V_BLANK - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_VBLANK,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] x_q, y_q;
    logic [CNT_W-1:0] pix_x_q, pix_y_q, frame_cnt_q;
    logic [BW-1:0]    blank_q;
    logic [1:0]       mode_q;
    logic             hsync_q, line_start_q, frame_start_q, busy_q, done_q;
    logic             abort_c;
    logic [CNT_W-1:0] frame_inc_c;
    logic             last_after_inc_c;
    logic             last_now_c;

`ifdef FRAME_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Run-complete tests: after the increment on the last pixel, and after vertical blanking.
    assign frame_inc_c      = frame_cnt_q + 1'b1;
    assign last_after_inc_c = (NUM_FRAMES != 0) && (frame_inc_c == CNT_W'(NUM_FRAMES));
    assign last_now_c       = (NUM_FRAMES != 0) && (frame_cnt_q == CNT_W'(NUM_FRAMES));

    // Sequencer: state, counters and registered outputs.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q       <= S_IDLE;
            x_q           <= '0;
            y_q           <= '0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_cnt_q   <= '0;
            blank_q       <= '0;
            mode_q        <= '0;
            hsync_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            hsync_q       <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
            if (abort_c && (state_q != S_IDLE)) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        busy_q <= 1'b0;
                        if (start) begin
                            mode_q      <= mode_in;
                            x_q         <= '0;
                            y_q         <= '0;
                            pix_x_q     <= '0;
                            pix_y_q     <= '0;
                            frame_cnt_q <= '0;
                            busy_q      <= 1'b1;
                            state_q     <= S_ACTIVE;
                        end
                    end
                    S_ACTIVE: begin
                        if (!stall) begin
                            hsync_q       <= 1'b1;
                            line_start_q  <= (x_q == '0);
                            frame_start_q <= (x_q == '0) && (y_q == '0);
                            pix_x_q       <= x_q;
                            pix_y_q       <= y_q;
                            blank_q       <= '0;
                            if (x_q != CNT_W'(IMG_W - 1)) begin
                                x_q <= x_q + 1'b1;
                            end else begin
                                x_q <= '0;
                                if (y_q != CNT_W'(IMG_H - 1)) begin
                                    y_q <= y_q + 1'b1;
                                    if (H_BLANK > 0) state_q <= S_HBLANK;
                                end else begin
                                    y_q         <= '0;
                                    frame_cnt_q <= frame_inc_c;
                                    if (V_BLANK > 0)           state_q <= S_VBLANK;
                                    else if (last_after_inc_c) state_q <= S_DONE;
                                end
                            end
                        end
                    end
                    S_HBLANK: begin
                        if (blank_q == BW'(HB_LAST)) state_q <= S_ACTIVE;
                        else                         blank_q <= blank_q + 1'b1;
                    end
                    S_VBLANK: begin
                        if (blank_q == BW'(VB_LAST)) state_q <= last_now_c ? S_DONE : S_ACTIVE;
                        else                         blank_q <= blank_q + 1'b1;
                    end
                    S_DONE: begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign HSYNC       = hsync_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;
    assign frame_cnt   = frame_cnt_q;
    assign mode        = mode_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_image_frame_ctrl.sv
// Directed bench for image_frame_ctrl: 4x3 frames, H_BLANK=2, V_BLANK=3, two frames per run.
module tb_image_frame_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             HCLK;
    logic             HRESETn;
    logic             start;
    logic [1:0]       mode_in;
    logic             stall;
`ifdef FRAME_ABORT_EN
    logic             abort;
`endif
    logic             HSYNC, line_start, frame_start, busy, done;
    logic [CNT_W-1:0] pix_x, pix_y, frame_cnt;
    logic [1:0]       mode;

    int errors = 0;
    int checks = 0;
    int hs_cnt;
    int done_cyc;
    int done_cnt;
    logic exp_hs;

    image_frame_ctrl #(
        .IMG_W(4), .IMG_H(3), .H_BLANK(2), .V_BLANK(3), .NUM_FRAMES(2), .CNT_W(CNT_W)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .mode_in(mode_in), .stall(stall),
`ifdef FRAME_ABORT_EN
        .abort(abort),
`endif
        .HSYNC(HSYNC), .line_start(line_start), .frame_start(frame_start),
        .pix_x(pix_x), .pix_y(pix_y), .frame_cnt(frame_cnt), .mode(mode),
        .busy(busy), .done(done)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_out();
        return 64'({HSYNC, line_start, frame_start, pix_x, pix_y, frame_cnt, mode, busy, done});
    endfunction

    initial begin
        HRESETn = 1'b0;
        start   = 1'b0;
        mode_in = 2'd0;
        stall   = 1'b0;
`ifdef FRAME_ABORT_EN
        abort   = 1'b0;
`endif
        tick();
        tick();
        check("reset_outputs", all_out(), 64'd0);
        HRESETn = 1'b1;
        repeat (5) tick();
        check("idle_outputs", all_out(), 64'd0);

        // Run 1: mode 2, no stall, a start pulse in the middle of the run must be ignored.
        start = 1'b1; mode_in = 2'd2;
        tick();
        check("r1_busy_at_start", 64'(busy), 64'd1);
        check("r1_mode", 64'(mode), 64'd2);
        check("r1_no_hsync_at_start", 64'(HSYNC), 64'd0);
        start = 1'b0;
        hs_cnt = 0;
        for (int c = 1; c <= 44; c++) begin
            start   = (c == 10);
            mode_in = (c == 10) ? 2'd1 : 2'd2;
            tick();
            exp_hs = (c >= 1 && c <= 4) || (c >= 7 && c <= 10) || (c >= 13 && c <= 16) ||
                     (c >= 20 && c <= 23) || (c >= 26 && c <= 29) || (c >= 32 && c <= 35);
            check("r1_hsync", 64'(HSYNC), 64'(exp_hs));
            check("r1_frame_start", 64'(frame_start), 64'(c == 1 || c == 20));
            check("r1_done", 64'(done), 64'(c == 39));
            check("r1_busy", 64'(busy), 64'(c <= 39));
            if (HSYNC) hs_cnt++;
            if (c == 7)  check("r1_line_start_y1", 64'(line_start), 64'd1);
            if (c == 9)  check("r1_pix_2_1", 64'({pix_x, pix_y}), 64'({16'd2, 16'd1}));
            if (c == 16) check("r1_frame0_end", 64'({pix_x, pix_y, frame_cnt}), 64'({16'd3, 16'd2, 16'd1}));
            if (c == 39) check("r1_done_state", 64'({frame_cnt, 14'd0, mode}), 64'({16'd2, 14'd0, 2'd2}));
        end
        start = 1'b0;
        check("r1_hsync_total", 64'(hs_cnt), 64'd24);
        check("r1_hold_after", 64'({frame_cnt, 14'd0, mode}), 64'({16'd2, 14'd0, 2'd2}));

        // Run 2: mode 3, stall for 3 cycles where pixel (2,1) is due.
        start = 1'b1; mode_in = 2'd3;
        tick();
        start = 1'b0;
        check("r2_frame_cnt_cleared", 64'(frame_cnt), 64'd0);
        hs_cnt = 0; done_cyc = 0;
        for (int c = 1; c <= 46; c++) begin
            stall = (c >= 9 && c <= 11);
            tick();
            if (HSYNC) hs_cnt++;
            if (done) done_cyc = c;
            if (c >= 9 && c <= 11)
                check("r2_stalled", 64'({HSYNC, pix_x, pix_y}), 64'({1'b0, 16'd1, 16'd1}));
            if (c == 12)
                check("r2_resume_2_1", 64'({HSYNC, pix_x, pix_y}), 64'({1'b1, 16'd2, 16'd1}));
        end
        stall = 1'b0;
        check("r2_done_cycle", 64'(done_cyc), 64'd42);
        check("r2_hsync_total", 64'(hs_cnt), 64'd24);
        check("r2_mode", 64'(mode), 64'd3);
        check("r2_idle", 64'(busy), 64'd0);

        // Run 3: start pulse mid-frame ignored, then reset in the middle of a line.
        start = 1'b1; mode_in = 2'd0;
        tick();
        for (int c = 1; c <= 8; c++) begin
            start   = (c == 5);
            mode_in = (c == 5) ? 2'd1 : 2'd0;
            tick();
        end
        start = 1'b0;
        check("r3_mid_line", 64'({HSYNC, pix_x, pix_y, 14'd0, mode}), 64'({1'b1, 16'd1, 16'd1, 14'd0, 2'd0}));
        HRESETn = 1'b0;
        tick();
        check("r3_reset_mid_line", all_out(), 64'd0);
        HRESETn = 1'b1;
        repeat (3) tick();
        check("r3_idle_after_reset", all_out(), 64'd0);

`ifdef FRAME_ABORT_EN
        // Abort at pixel (1,2) of frame 0; start wins over abort in IDLE.
        start = 1'b1; abort = 1'b1; mode_in = 2'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("ab_start_wins", 64'(busy), 64'd1);
        for (int c = 1; c <= 13; c++) tick();
        check("ab_before", 64'({HSYNC, pix_x, pix_y}), 64'({1'b1, 16'd0, 16'd2}));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_idle", 64'({HSYNC, busy, frame_cnt}), 64'({1'b0, 1'b0, 16'd0}));
        done_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (done || HSYNC) done_cnt++;
        end
        check("ab_no_done", 64'(done_cnt), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_in_idle", 64'({busy, frame_cnt}), 64'({1'b0, 16'd0}));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
